// File: rtl/demux_pkg.sv
// Shared types and constants for the round-robin lane demux scheduler.
package demux_pkg;

  localparam int unsigned N_CH  = 8;
  localparam int unsigned SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [N_CH-1:0]  lane_vec_t;

  typedef enum logic {
    EMPTY,
    FULL
  } sched_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set bit of mask at or after ptr, wrapping.
module rr_pick
  import demux_pkg::*;
(
  input  lane_vec_t mask,
  input  sel_t      ptr,
  output logic      found,
  output sel_t      idx
);

  sel_t cand;

  always_comb begin
    found = |mask;
    idx   = '0;
    cand  = '0;
    // Walk offsets from farthest to nearest so the nearest hit wins.
    for (int k = N_CH - 1; k >= 0; k--) begin
      cand = ptr + sel_t'(k);
      if (mask[cand]) begin
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/demux_rr_sched.sv
// Round-robin scheduler feeding one input word stream to 8 lanes through a
// single hold register, with per-lane enable mask and stall timeout.
module demux_rr_sched
  import demux_pkg::*;
#(
  parameter int unsigned DW      = 8,
  parameter int unsigned N_CH    = demux_pkg::N_CH,
  parameter int unsigned SEL_W   = demux_pkg::SEL_W,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  en_mask,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             in_ready,
  output logic [N_CH-1:0]  out_valid,
  output logic [DW-1:0]    out_data,
  input  logic [N_CH-1:0]  out_ready,
  output logic [SEL_W-1:0] sel,
  output logic             drop,
  output logic             busy
);

  sched_state_t  state_q, state_d;
  sel_t          ptr_q, ptr_d;
  sel_t          sel_q, sel_d;
  logic [DW-1:0] data_q, data_d;
  logic [7:0]    stall_q, stall_d;
  logic          drop_q, drop_d;

  logic pick_found;
  sel_t pick_idx;
  logic lane_fire;
  logic accept;
  logic timeout;

  rr_pick u_rr_pick (
    .mask  (lane_vec_t'(en_mask)),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    lane_fire = (state_q == FULL) && out_ready[sel_q];
    in_ready  = pick_found && ((state_q == EMPTY) || lane_fire);
    accept    = in_valid && in_ready;
    timeout   = (state_q == FULL) && !lane_fire && (stall_q == 8'(TIMEOUT - 1));

    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    stall_d = stall_q;
    drop_d  = 1'b0;

    // Accept takes precedence so a firing lane and a new word overlap with no bubble.
    if (accept) begin
      state_d = FULL;
      sel_d   = pick_idx;
      ptr_d   = pick_idx + sel_t'(1);
      data_d  = in_data;
      stall_d = '0;
    end else if (lane_fire) begin
      state_d = EMPTY;
      stall_d = '0;
    end else if (timeout) begin
      state_d = EMPTY;
      drop_d  = 1'b1;
      stall_d = '0;
    end else if (state_q == FULL) begin
      stall_d = stall_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      stall_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      stall_q <= stall_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    out_valid = '0;
    if (state_q == FULL) begin
      out_valid = N_CH'(1) << sel_q;
    end
    out_data = data_q;
    sel      = SEL_W'(sel_q);
    drop     = drop_q;
    busy     = (state_q == FULL);
  end

endmodule

// File: tb/tb_demux_rr_sched.sv
// Bench for demux_rr_sched: directed scenarios plus random traffic, all
// checked against a queue-free behavioural model of the scheduling rules.
module tb_demux_rr_sched;

  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] en_mask;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] out_valid;
  logic [7:0] out_data;
  logic [7:0] out_ready;
  logic [2:0] sel;
  logic       drop;
  logic       busy;

  always #5 clk = ~clk;

  demux_rr_sched #(
    .DW      (8),
    .TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en_mask   (en_mask),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel       (sel),
    .drop      (drop),
    .busy      (busy)
  );

  int nchk = 0;
  int nerr = 0;

  // Model: is a word held, for which lane, which word, how long stalled.
  bit         m_full;
  bit         m_drop;
  int         m_lane;
  int         m_ptr;
  int         m_stall;
  logic [7:0] m_data;

  logic [21:0] exp_v;
  logic [21:0] obs_v;
  assign obs_v = {in_ready, out_valid, out_data, sel, drop, busy};

  function automatic logic [21:0] model_out();
    logic       fire;
    logic       ir;
    logic [7:0] ov;
    fire = m_full && out_ready[m_lane];
    ir   = (en_mask != 8'h00) && (!m_full || fire);
    ov   = m_full ? 8'(1 << m_lane) : 8'h00;
    return {ir, ov, m_data, 3'(m_lane), m_drop, m_full};
  endfunction

  task automatic drive(input logic r, input logic v, input logic [7:0] d,
                       input logic [7:0] mask, input logic [7:0] rdy);
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    in_data   = d;
    en_mask   = mask;
    out_ready = rdy;
    #1;
    exp_v = model_out();
  endtask

  task automatic tick();
    logic fire;
    logic ir;
    int   tgt;
    fire = m_full && out_ready[m_lane];
    ir   = (en_mask != 8'h00) && (!m_full || fire);
    tgt  = -1;
    for (int k = 0; k < 8; k++) begin
      if (tgt < 0 && en_mask[(m_ptr + k) % 8]) tgt = (m_ptr + k) % 8;
    end
    @(posedge clk);
    if (rst) begin
      m_full = 0; m_drop = 0; m_lane = 0; m_ptr = 0; m_stall = 0; m_data = 8'h00;
    end else begin
      m_drop = 0;
      if (in_valid && ir) begin
        m_lane  = tgt;
        m_ptr   = (tgt + 1) % 8;
        m_data  = in_data;
        m_full  = 1;
        m_stall = 0;
      end else if (fire) begin
        m_full  = 0;
        m_stall = 0;
      end else if (m_full) begin
        if (m_stall == TMO - 1) begin
          m_full  = 0;
          m_drop  = 1;
          m_stall = 0;
        end else begin
          m_stall++;
        end
      end
    end
  endtask

  task automatic check_model(input string name);
    nchk++;
    if (obs_v !== exp_v) begin
      nerr++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, obs_v, exp_v, $time);
    end
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    nchk++;
    if (obs_v !== 22'h0) begin
      nerr++;
      $display("FAIL reset_state: got %h want %h", obs_v, 22'h0);
    end
    check_model("reset_model");
    tick();
  endtask

  task automatic test_rotation();
    do_reset();
    for (int k = 0; k <= 10; k++) begin
      drive(1'b0, k < 10, 8'(k), 8'hFF, 8'hFF);
      if (k >= 1) begin
        nchk++;
        if (out_valid !== 8'(1 << ((k - 1) % 8)) || out_data !== 8'(k - 1) || drop !== 1'b0) begin
          nerr++;
          $display("FAIL rotation[%0d]: got ov=%h d=%h drop=%b want ov=%h d=%h drop=0",
                   k, out_valid, out_data, drop, 8'(1 << ((k - 1) % 8)), 8'(k - 1));
        end
      end
      check_model("rotation_model");
      tick();
    end
  endtask

  task automatic test_masked();
    int lanes[6] = '{2, 5, 7, 2, 5, 7};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b1, 8'(8'h10 + k), 8'b1010_0100, 8'hFF);
      if (k >= 1) begin
        nchk++;
        if (out_valid !== 8'(1 << lanes[k - 1])) begin
          nerr++;
          $display("FAIL masked[%0d]: got ov=%h want ov=%h", k, out_valid, 8'(1 << lanes[k - 1]));
        end
      end
      check_model("masked_model");
      tick();
    end
    // Word 0x15 is held for lane 7; mask switches to lane 0 only.
    drive(1'b0, 1'b1, 8'h20, 8'h01, 8'h00);
    nchk++;
    if (out_valid !== 8'h80 || out_data !== 8'h15 || in_ready !== 1'b0) begin
      nerr++;
      $display("FAIL mask_change_hold: got ov=%h d=%h ir=%b want ov=80 d=15 ir=0",
               out_valid, out_data, in_ready);
    end
    check_model("mask_change_model");
    tick();
    drive(1'b0, 1'b1, 8'h20, 8'h01, 8'hFF);
    nchk++;
    if (out_valid !== 8'h80 || in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL mask_change_release: got ov=%h ir=%b want ov=80 ir=1", out_valid, in_ready);
    end
    check_model("mask_change_model");
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, k == 0, 8'h21, 8'h01, 8'hFF);
      nchk++;
      if (out_valid !== 8'h01 || out_data !== 8'(8'h20 + k)) begin
        nerr++;
        $display("FAIL mask_change_lane0[%0d]: got ov=%h d=%h want ov=01 d=%h",
                 k, out_valid, out_data, 8'(8'h20 + k));
      end
      check_model("mask_change_model");
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1'b0, 1'b1, 8'hA5, 8'h08, 8'h00);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 8'h5A, 8'hFF, 8'h00);
      nchk++;
      if (in_ready !== 1'b0 || sel !== 3'd3 || out_valid !== 8'h08 || out_data !== 8'hA5) begin
        nerr++;
        $display("FAIL backpressure[%0d]: got ir=%b sel=%0d ov=%h d=%h want ir=0 sel=3 ov=08 d=a5",
                 k, in_ready, sel, out_valid, out_data);
      end
      check_model("backpressure_model");
      tick();
    end
    drive(1'b0, 1'b1, 8'h5A, 8'hFF, 8'h08);
    nchk++;
    if (in_ready !== 1'b1 || out_valid !== 8'h08) begin
      nerr++;
      $display("FAIL bp_release: got ir=%b ov=%h want ir=1 ov=08", in_ready, out_valid);
    end
    check_model("bp_release_model");
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'hFF, 8'hFF);
    nchk++;
    if (out_valid !== 8'h10 || out_data !== 8'h5A) begin
      nerr++;
      $display("FAIL bp_next_word: got ov=%h d=%h want ov=10 d=5a", out_valid, out_data);
    end
    check_model("bp_next_model");
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    drive(1'b0, 1'b1, 8'h77, 8'h10, 8'h00);
    tick();
    for (int c = 0; c <= 16; c++) begin
      drive(1'b0, 1'b0, 8'h00, 8'h10, 8'hEF);
      nchk++;
      if (drop !== (c == 15) || busy !== (c < 15)) begin
        nerr++;
        $display("FAIL timeout[%0d]: got drop=%b busy=%b want drop=%b busy=%b",
                 c, drop, busy, c == 15, c < 15);
      end
      check_model("timeout_model");
      tick();
    end
    drive(1'b0, 1'b1, 8'h66, 8'hFF, 8'hEF);
    check_model("timeout_accept_model");
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'hFF, 8'hEF);
    nchk++;
    if (sel !== 3'd5 || out_valid !== 8'h20 || out_data !== 8'h66) begin
      nerr++;
      $display("FAIL timeout_next_lane: got sel=%0d ov=%h d=%h want sel=5 ov=20 d=66",
               sel, out_valid, out_data);
    end
    tick();
  endtask

  task automatic test_empty_mask();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, 8'h3C, 8'h00, 8'hFF);
      nchk++;
      if (in_ready !== 1'b0 || out_valid !== 8'h00) begin
        nerr++;
        $display("FAIL empty_mask[%0d]: got ir=%b ov=%h want ir=0 ov=00", k, in_ready, out_valid);
      end
      check_model("empty_mask_model");
      tick();
    end
    drive(1'b0, 1'b1, 8'h3C, 8'h80, 8'hFF);
    check_model("mask80_accept_model");
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h80, 8'hFF);
    nchk++;
    if (out_valid !== 8'h80 || out_data !== 8'h3C) begin
      nerr++;
      $display("FAIL mask80_route: got ov=%h d=%h want ov=80 d=3c", out_valid, out_data);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b1, 8'h99, 8'hFF, 8'h00);
    tick();
    drive(1'b1, 1'b0, 8'h00, 8'hFF, 8'h00);
    check_model("pre_reset_model");
    tick();
    drive(1'b0, 1'b1, 8'h42, 8'hFF, 8'hFF);
    nchk++;
    if (out_valid !== 8'h00 || busy !== 1'b0 || sel !== 3'd0 || drop !== 1'b0) begin
      nerr++;
      $display("FAIL reset_mid: got ov=%h busy=%b sel=%0d drop=%b want 00 0 0 0",
               out_valid, busy, sel, drop);
    end
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'hFF, 8'hFF);
    nchk++;
    if (out_valid !== 8'h01 || out_data !== 8'h42) begin
      nerr++;
      $display("FAIL reset_next_lane: got ov=%h d=%h want ov=01 d=42", out_valid, out_data);
    end
    tick();
  endtask

  task automatic test_random();
    logic [7:0] mask;
    logic [7:0] rdy;
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 3))
        0:       mask = 8'(1 << $urandom_range(0, 7));
        1:       mask = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
        2:       mask = 8'hFF;
        default: mask = 8'($urandom);
      endcase
      // Periodic long stall windows so timeouts occur.
      rdy = ((c % 60) >= 35) ? 8'h00 : 8'($urandom);
      drive($urandom_range(0, 99) == 0, 1'($urandom), 8'($urandom), mask, rdy);
      check_model("random");
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; en_mask = '0; out_ready = '0;
    m_full = 0; m_drop = 0; m_lane = 0; m_ptr = 0; m_stall = 0; m_data = 8'h00;
    test_reset();
    test_rotation();
    test_masked();
    test_backpressure();
    test_timeout();
    test_empty_mask();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/demux_rr_sched.md
Name: demux_rr_sched

Overview:
- Round-robin scheduler that distributes a single valid/ready input word stream across 8 output lanes.
- Drives a shared data bus plus a one-hot lane valid, i.e. it sequences the select of a 1:8 demultiplexer.
- Holds each accepted word in a one-entry output register until the chosen lane accepts it or a stall timeout expires.
- Sits between a single producer and 8 per-lane consumers. Per-lane enable mask comes from configuration.

Parameters:
- DW, 8, data word width.
- N_CH, 8, lane count (fixed at 8; SEL_W derives from it).
- SEL_W, 3, lane select width, equal to clog2(N_CH).
- TIMEOUT, 15, stall cycles tolerated before the held word is dropped. Range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- en_mask  in  8  per-lane enable; bit i=1 makes lane i eligible
- in_valid  in  1  producer word valid
- in_data  in  DW  producer word
- in_ready  out  1  block can accept a word this cycle
- out_valid  out  8  one-hot lane valid (all zero when empty)
- out_data  out  DW  shared lane data bus
- out_ready  in  8  per-lane consumer ready
- sel  out  SEL_W  lane index of the held word (demux select)
- drop  out  1  one-cycle pulse: held word discarded on timeout
- busy  out  1  hold register full

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst; all state is sampled on the rising edge of clk.
- Reset values: ptr=0, sel=0, hold empty (state EMPTY), out_valid=0, out_data=0, drop=0, busy=0, stall_cnt=0.
- State machine with two states:
  - EMPTY: hold register empty.
  - FULL: hold register holds a word for lane sel.
- out_valid = (state==FULL) ? (1<<sel) : 0.
- out_data = held word, registered. Its value is don't-care in EMPTY but it holds its last value.
- busy = (state==FULL).
- Delivery: in FULL, the word is delivered when out_ready[sel]=1 (lane_fire).
- in_ready = (en_mask!=0) && (state==EMPTY || lane_fire). Combinational from registered state, out_ready and en_mask.
- Accept: in_valid && in_ready.
  - Target lane = first i with en_mask[i]=1, searching ptr, ptr+1, … wrapping mod 8.
  - Capture in_data; sel=target; ptr=(target+1) mod 8; state=FULL; stall_cnt=0.
- Lane is fixed at accept time. A later en_mask change does not redirect a held word.
- lane_fire without a new accept: state goes to EMPTY and ptr is unchanged.
- Simultaneous lane_fire and accept: back-to-back transfer, one word per cycle, no bubble.
- Stall counting: in FULL without lane_fire, stall_cnt increments.
- Timeout: when stall_cnt==TIMEOUT-1 and still no lane_fire:
  - held word discarded, state goes to EMPTY, drop=1 for one cycle, stall_cnt=0.
  - in_ready stays 0 in that cycle; no accept occurs.
- en_mask==0: no accepts. A word already held is still delivered or times out normally.
- Single enabled lane: every word goes to that lane and ptr stays at lane+1.
- Wrap-around: ptr=7 with lane 7 selected sets ptr to 0.
- rst asserted mid-transfer: held word is lost with no drop pulse, and all state returns to reset values the next cycle.
- Latency: an accepted word appears on out_valid/out_data in the cycle after acceptance. Minimum occupancy is 1 cycle.

Decomposition:
- Shared package demux_pkg holds:
  - constants N_CH=8 and SEL_W=3
  - typedef sel_t (logic [SEL_W-1:0]) and lane_vec_t (logic [N_CH-1:0])
  - state enum sched_state_t {EMPTY, FULL}
- One sub-module, rr_pick: combinational rotating priority encoder.
  - Inputs: mask, ptr.
  - Outputs: found, idx.
  - Instantiated once for target selection.

Test Plan:
- Round-robin rotation:
  - Stimulus: en_mask=8'hFF, out_ready=8'hFF, 10 consecutive words 0x00..0x09.
  - Required: lanes 0,1,…,7,0,1 in order, one per cycle, out_valid one-hot each cycle, no bubble, drop never asserted.
- Masked lanes:
  - Stimulus: en_mask=8'b1010_0100, 6 words.
  - Required: lanes 2,5,7,2,5,7.
  - Then set mask to 8'h01 mid-stream: a word held for lane 7 still goes to lane 7, and subsequent words go to lane 0.
- Backpressure:
  - Stimulus: lane 3 out_ready=0 for 4 cycles with word 0xA5 held.
  - Required: in_ready=0, sel=3, out_valid=8'h08 stable, out_data=0xA5 stable.
  - Release: delivered that cycle, and a concurrent new word is accepted with no bubble.
- Timeout:
  - Stimulus: TIMEOUT=15, lane 4 out_ready stuck 0.
  - Required: drop pulses exactly one cycle, 15 cycles after out_valid rose; state returns to EMPTY; next word goes to lane 5.
- Empty mask:
  - Stimulus: en_mask=0 with in_valid=1 for 5 cycles.
  - Required: in_ready=0 and out_valid=0 throughout.
  - Then mask=8'h80: the word is accepted and routed to lane 7.
- Reset mid-operation:
  - Stimulus: rst=1 for one cycle while FULL.
  - Required: next cycle out_valid=0, busy=0, sel=0, drop=0, and the next word goes to lane 0.
